// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag vector type and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpNand = 4'd5,
        OpNor  = 4'd6,
        OpXnor = 4'd7,
        OpShl  = 4'd8,
        OpShr  = 4'd9,
        OpRol  = 4'd10,
        OpRor  = 4'd11,
        OpInc  = 4'd12,
        OpDec  = 4'd13,
        OpEq   = 4'd14,
        OpLtu  = 4'd15
    } alu_op_e;

    typedef logic [3:0] alu_flags_t;

    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU evaluator: one result and {V,N,Z,C} flags per opcode,
// with optional unsigned saturation for ADD/SUB/INC/DEC.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] c,
    output alu_flags_t        flags
);

    localparam int unsigned SW  = $clog2(DATA_W);
    localparam int unsigned MSB = DATA_W - 1;

    logic [SW-1:0]       amt;
    logic [SW-1:0]       rot;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   res;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     shl_w;
    logic [DATA_W:0]     shr_w;
    logic [2*DATA_W-1:0] rol_w;
    logic [2*DATA_W-1:0] ror_w;
    logic                carry;
    logic                ovf;

    always_comb begin
        amt  = b[SW-1:0];
        // Rotation is modulo the width so non-power-of-two widths stay well defined.
        rot  = SW'(32'(amt) % DATA_W);
        opnd = (op == OpInc || op == OpDec) ? DATA_W'(1) : b;
        sum  = {1'b0, a} + {1'b0, opnd};
        diff = {1'b0, a} - {1'b0, opnd};
        // One guard bit on each side captures the last bit shifted out.
        shl_w = {1'b0, a} << amt;
        shr_w = {a, 1'b0} >> amt;
        rol_w = {a, a} << rot;
        ror_w = {a, a} >> rot;

        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;

        unique case (op)
            OpAdd, OpInc: begin
                res   = sum[MSB:0];
                carry = sum[DATA_W];
                ovf   = (a[MSB] == opnd[MSB]) && (sum[MSB] != a[MSB]);
                if (SAT_EN && carry) res = '1;
            end
            OpSub, OpDec: begin
                res   = diff[MSB:0];
                carry = diff[DATA_W];
                ovf   = (a[MSB] != opnd[MSB]) && (diff[MSB] != a[MSB]);
                if (SAT_EN && carry) res = '0;
            end
            OpAnd:  res = a & b;
            OpOr:   res = a | b;
            OpXor:  res = a ^ b;
            OpNand: res = ~(a & b);
            OpNor:  res = ~(a | b);
            OpXnor: res = ~(a ^ b);
            OpShl: begin
                res   = shl_w[MSB:0];
                carry = shl_w[DATA_W];
            end
            OpShr: begin
                res   = shr_w[DATA_W:1];
                carry = shr_w[0];
            end
            OpRol: begin
                res   = rol_w[2*DATA_W-1:DATA_W];
                carry = (amt != '0) && res[0];
            end
            OpRor: begin
                res   = ror_w[MSB:0];
                carry = (amt != '0) && res[MSB];
            end
            OpEq:  res = {{(DATA_W-1){1'b0}}, (a == b)};
            OpLtu: res = {{(DATA_W-1){1'b0}}, (a < b)};
            default: ;
        endcase

        c            = res;
        flags        = '0;
        flags[FLG_C] = carry;
        flags[FLG_Z] = (res == '0);
        flags[FLG_N] = res[MSB];
        flags[FLG_V] = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: alu_core result registered through STAGES valid/ready stages
// with full backpressure and a combinational ready chain.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned STAGES = 2,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  alu_op_e           in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output alu_flags_t        out_flags,
    output logic              busy
);

    logic [DATA_W-1:0] core_c;
    alu_flags_t        core_flags;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] load;
    logic [DATA_W-1:0] c_q     [STAGES];
    alu_flags_t        flags_q [STAGES];

    alu_core #(
        .DATA_W(DATA_W),
        .SAT_EN(SAT_EN)
    ) u_core (
        .a    (in_a),
        .b    (in_b),
        .op   (in_op),
        .c    (core_c),
        .flags(core_flags)
    );

    // A stage loads when empty or when its content moves on this cycle;
    // walking from the output back gives a bubble-free ready chain.
    always_comb begin
        logic nxt;
        nxt  = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load[i] = !valid_q[i] || nxt;
            nxt     = load[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                c_q[i]     <= '0;
                flags_q[i] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    c_q[0]     <= core_c;
                    flags_q[0] <= core_flags;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        c_q[i]     <= c_q[i-1];
                        flags_q[i] <= flags_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_c     = c_q[STAGES-1];
    assign out_flags = flags_q[STAGES-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a wrapping and a saturating instance share stimulus.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    alu_op_e      in_op;
    logic         out_ready;

    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_c;
    logic [3:0]   out_flags;
    logic         in_ready_s, out_valid_s, busy_s;
    logic [W-1:0] out_c_s;
    logic [3:0]   out_flags_s;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(W), .STAGES(S), .SAT_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_c(out_c), .out_flags(out_flags), .busy(busy)
    );

    alu_pipe #(.DATA_W(W), .STAGES(S), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_c(out_c_s), .out_flags(out_flags_s), .busy(busy_s)
    );

    typedef struct {
        logic [W-1:0] c;
        logic [3:0]   f;
        int unsigned  cyc;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [3:0]   f;
        logic [W-1:0] cs;
        logic [3:0]   fs;
    } dir_t;

    // {op, a, b, c, {V,N,Z,C}, saturating c, saturating flags}
    dir_t dirs [16] = '{
        '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011, 8'hFF, 4'b0101},
        '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000, 8'h7F, 4'b1000},
        '{4'd1,  8'h03, 8'h05, 8'hFE, 4'b0101, 8'h00, 4'b0011},
        '{4'd8,  8'h81, 8'h01, 8'h02, 4'b0001, 8'h02, 4'b0001},
        '{4'd11, 8'h01, 8'h03, 8'h20, 4'b0000, 8'h20, 4'b0000},
        '{4'd11, 8'h01, 8'h01, 8'h80, 4'b0101, 8'h80, 4'b0101},
        '{4'd9,  8'h5A, 8'h00, 8'h5A, 4'b0000, 8'h5A, 4'b0000},
        '{4'd10, 8'h81, 8'h01, 8'h03, 4'b0001, 8'h03, 4'b0001},
        '{4'd8,  8'h01, 8'h09, 8'h02, 4'b0000, 8'h02, 4'b0000},
        '{4'd12, 8'hFF, 8'h00, 8'h00, 4'b0011, 8'hFF, 4'b0101},
        '{4'd12, 8'h7F, 8'h00, 8'h80, 4'b1100, 8'h80, 4'b1100},
        '{4'd13, 8'h00, 8'h00, 8'hFF, 4'b0101, 8'h00, 4'b0011},
        '{4'd13, 8'h80, 8'h00, 8'h7F, 4'b1000, 8'h7F, 4'b1000},
        '{4'd14, 8'h33, 8'h33, 8'h01, 4'b0000, 8'h01, 4'b0000},
        '{4'd15, 8'h03, 8'h02, 8'h00, 4'b0010, 8'h00, 4'b0010},
        '{4'd5,  8'hFF, 8'hFF, 8'h00, 4'b0010, 8'h00, 4'b0010}
    };

    exp_t         q0[$];
    exp_t         q1[$];
    int           checks = 0;
    int           errors = 0;
    int unsigned  cyc = 0;
    bit           lat_chk = 1'b0;
    bit           fired;
    logic [W-1:0] e_c, e_cs;
    logic [3:0]   e_f, e_fs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model written as bit-serial shifts and integer arithmetic.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input bit sat);
        int ua, ub, sa, sb, t;
        logic [7:0] r;
        bit cf, vf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 8'h00;
        cf = 1'b0;
        vf = 1'b0;
        t  = 0;
        case (op)
            4'd0: begin
                t = ua + ub; r = t[7:0]; cf = t > 255;
                vf = (sa + sb > 127) || (sa + sb < -128);
                if (sat && cf) r = 8'hFF;
            end
            4'd1: begin
                t = ua - ub; r = t[7:0]; cf = ua < ub;
                vf = (sa - sb > 127) || (sa - sb < -128);
                if (sat && cf) r = 8'h00;
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = ~(a ^ b);
            4'd8, 4'd9, 4'd10, 4'd11: begin
                r = a;
                for (int k = 0; k < int'(b[2:0]); k++) begin
                    case (op)
                        4'd8:    begin cf = r[7]; r = {r[6:0], 1'b0}; end
                        4'd9:    begin cf = r[0]; r = {1'b0, r[7:1]}; end
                        4'd10:   begin cf = r[7]; r = {r[6:0], r[7]}; end
                        default: begin cf = r[0]; r = {r[0], r[7:1]}; end
                    endcase
                end
            end
            4'd12: begin
                t = ua + 1; r = t[7:0]; cf = t > 255; vf = sa + 1 > 127;
                if (sat && cf) r = 8'hFF;
            end
            4'd13: begin
                t = ua - 1; r = t[7:0]; cf = ua == 0; vf = sa - 1 < -128;
                if (sat && cf) r = 8'h00;
            end
            4'd14: r = (a == b) ? 8'h01 : 8'h00;
            default: r = (ua < ub) ? 8'h01 : 8'h00;
        endcase
        return {vf, r[7], (r == 8'h00), cf, r};
    endfunction

    // Sample handshakes mid-cycle, then advance to just past the next rising edge.
    task automatic tick();
        #2;
        if (in_valid && in_ready) begin
            q0.push_back('{c: e_c, f: e_f, cyc: cyc});
            fired = 1'b1;
        end
        if (in_valid && in_ready_s) q1.push_back('{c: e_cs, f: e_fs, cyc: cyc});
        if (out_valid && out_ready) begin
            if (q0.size() == 0) check("unexpected_out", 32'(out_c), 32'hDEAD);
            else begin
                exp_t x;
                x = q0.pop_front();
                check("out_c", 32'(out_c), 32'(x.c));
                check("out_flags", 32'(out_flags), 32'(x.f));
                if (lat_chk) check("latency", cyc - x.cyc, S);
            end
        end
        if (out_valid_s && out_ready) begin
            if (q1.size() == 0) check("unexpected_out_sat", 32'(out_c_s), 32'hDEAD);
            else begin
                exp_t x;
                x = q1.pop_front();
                check("sat_out_c", 32'(out_c_s), 32'(x.c));
                check("sat_out_flags", 32'(out_flags_s), 32'(x.f));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ec, input logic [3:0] ef,
                          input logic [7:0] ecs, input logic [3:0] efs);
        in_op = alu_op_e'(op);
        in_a  = a;
        in_b  = b;
        e_c   = ec;
        e_f   = ef;
        e_cs  = ecs;
        e_fs  = efs;
    endtask

    task automatic set_rand();
        logic [3:0] op;
        logic [7:0] a, b;
        logic [11:0] m, ms;
        op = 4'($urandom_range(0, 15));
        a  = 8'($urandom);
        b  = 8'($urandom);
        m  = model(a, b, op, 1'b0);
        ms = model(a, b, op, 1'b1);
        set_op(op, a, b, m[7:0], m[11:8], ms[7:0], ms[11:8]);
    endtask

    task automatic send();
        in_valid = 1'b1;
        fired    = 1'b0;
        for (int n = 0; n < 50 && !fired; n++) tick();
        if (!fired) check("accept_timeout", 32'(fired), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) tick();
        check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        int acc;
        bit have;
        logic [7:0] hold_c;
        logic [3:0] hold_f;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = OpAdd;
        e_c = '0; e_f = '0; e_cs = '0; e_fs = '0; fired = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, streamed back to back
        lat_chk   = 1'b1;
        out_ready = 1'b1;
        foreach (dirs[i]) begin
            set_op(dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].c, dirs[i].f,
                   dirs[i].cs, dirs[i].fs);
            send();
        end
        drain();

        // Back-to-back random stream: in_ready must hold high every cycle
        for (int i = 0; i < 10; i++) begin
            set_rand();
            in_valid = 1'b1;
            fired    = 1'b0;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("b2b_accept", 32'(fired), 32'd1);
        end
        drain();
        lat_chk = 1'b0;

        // Stall: output blocked, input offered for 5 cycles
        out_ready = 1'b0;
        acc  = 0;
        have = 1'b0;
        hold_c = '0;
        hold_f = '0;
        set_rand();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fired = 1'b0;
            tick();
            if (fired) begin
                acc++;
                set_rand();
            end
            if (out_valid) begin
                if (!have) begin
                    hold_c = out_c;
                    hold_f = out_flags;
                    have   = 1'b1;
                end else begin
                    check("stall_c_stable", 32'(out_c), 32'(hold_c));
                    check("stall_f_stable", 32'(out_flags), 32'(hold_f));
                end
            end
        end
        check("stall_accepts", 32'(acc), S);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        drain();

        // Random traffic with random backpressure
        set_rand();
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            fired = 1'b0;
            tick();
            if (fired) set_rand();
        end
        drain();

        // Reset with two entries in flight
        set_rand();
        send();
        set_rand();
        send();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sat_busy", 32'(busy_s), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_chk = 1'b1;
        set_rand();
        send();
        drain();
        repeat (4) begin
            tick();
            check("post_rst_idle", 32'(out_valid | out_valid_s), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
